// File: rtl/fifo_param_if.sv
// Producer/consumer bus for fifo_param. The master modport is the side that
// drives write data and read/write requests; the slave modport is the FIFO.
interface fifo_param_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             fifo_on;
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output fifo_on, din, wr_en, rd_en,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  fifo_on, din, wr_en, rd_en,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags and overflow/underflow error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise dout is
// loaded one cycle after an accepted read.
module fifo_param #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input logic         clk,
  input logic         rst,
  fifo_param_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] AfullTh  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AemptyTh = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             aempty_q, aempty_d, afull_q, afull_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // A write into a full FIFO is still accepted if a read frees a slot on the same edge.
  assign rd_acc = bus.fifo_on & bus.rd_en & ~empty_q;
  assign wr_acc = bus.fifo_on & bus.wr_en & (~full_q | rd_acc);

  // Next-state for pointers, occupancy, flags, error pulses and read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d  = (count_d == '0);
    full_d   = (count_d == DepthCnt);
    aempty_d = (count_d <= AemptyTh);
    afull_d  = (count_d >= AfullTh);
    ovf_d    = bus.fifo_on & bus.wr_en & full_q & ~rd_acc;
    unf_d    = bus.fifo_on & bus.rd_en & empty_q;

`ifdef FIFO_FWFT_EN
    // Present the head entry as it will be after this edge; bypass din when the
    // head slot is being written right now (write into an empty FIFO).
    if (count_d != '0) begin
      if (wr_acc && (wr_ptr_q == rd_ptr_d)) dout_d = bus.din;
      else                                  dout_d = mem_q[rd_ptr_d];
    end
`else
    if (rd_acc) dout_d = mem_q[rd_ptr_q];
`endif
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.din;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= (AfullTh == '0);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (WIDTH=8, DEPTH=8,
// AFULL_THRESH=6, AEMPTY_THRESH=2). Works in both read modes; FWFT-only
// checks are enabled with FIFO_FWFT_EN.
module tb_fifo_param;
  localparam int unsigned W = 8;
  localparam int unsigned D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_param #(
    .WIDTH        (W),
    .DEPTH        (D),
    .AFULL_THRESH (6),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    bus.wr_en = 1'b1;
    bus.din   = d;
    cycle();
    bus.wr_en = 1'b0;
  endtask

  // Returns the word consumed by one pop, whichever read mode is built.
  task automatic pop(output logic [W-1:0] d);
`ifdef FIFO_FWFT_EN
    d = bus.dout;
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
`else
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    d = bus.dout;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) cycle();
    tests++;
    if (bus.count !== 4'd0) begin
      fails++; $display("FAIL reset_count: got %0d exp 0", bus.count);
    end
    tests++;
    if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow}
        !== 6'b101000) begin
      fails++;
      $display("FAIL reset_flags: got %b exp 101000", {bus.empty, bus.full, bus.almost_empty,
               bus.almost_full, bus.overflow, bus.underflow});
    end
    tests++;
    if (bus.dout !== 8'h00) begin
      fails++; $display("FAIL reset_dout: got %h exp 00", bus.dout);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_fill();
    bus.fifo_on = 1'b1;
    for (int i = 0; i < 6; i++) push(W'(i));
    tests++;
    if (bus.count !== 4'd6) begin
      fails++; $display("FAIL fill_count: got %0d exp 6", bus.count);
    end
    tests++;
    if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== 4'b0001) begin
      fails++; $display("FAIL fill_flags: got %b exp 0001",
                        {bus.empty, bus.full, bus.almost_empty, bus.almost_full});
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] d;
    for (int i = 0; i < 6; i++) begin
      pop(d);
      tests++;
      if (d !== W'(i)) begin
        fails++; $display("FAIL drain_data[%0d]: got %h exp %h", i, d, W'(i));
      end
    end
    tests++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin
      fails++; $display("FAIL drain_empty: got empty=%b count=%0d exp 1/0", bus.empty, bus.count);
    end
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    tests++;
    if (bus.underflow !== 1'b1) begin
      fails++; $display("FAIL underflow_pulse: got %b exp 1", bus.underflow);
    end
`ifndef FIFO_FWFT_EN
    tests++;
    if (bus.dout !== 8'h05) begin
      fails++; $display("FAIL underflow_dout_hold: got %h exp 05", bus.dout);
    end
`endif
    cycle();
    tests++;
    if (bus.underflow !== 1'b0) begin
      fails++; $display("FAIL underflow_one_cycle: got %b exp 0", bus.underflow);
    end
  endtask

  task automatic test_overflow_wrap();
    logic [W-1:0] d;
    logic [W-1:0] exp_q [12];
    for (int i = 0; i < 8; i++) push(8'h10 + W'(i));
    tests++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
      fails++; $display("FAIL wrap_full: got full=%b count=%0d exp 1/8", bus.full, bus.count);
    end
    push(8'h18);
    tests++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
      fails++; $display("FAIL overflow_pulse: got ovf=%b count=%0d exp 1/8",
                        bus.overflow, bus.count);
    end
    cycle();
    tests++;
    if (bus.overflow !== 1'b0) begin
      fails++; $display("FAIL overflow_one_cycle: got %b exp 0", bus.overflow);
    end
    for (int i = 0; i < 8; i++) exp_q[i] = 8'h10 + W'(i);
    for (int i = 0; i < 4; i++) exp_q[8 + i] = 8'h20 + W'(i);
    for (int i = 0; i < 4; i++) begin
      pop(d);
      tests++;
      if (d !== exp_q[i]) begin
        fails++; $display("FAIL wrap_read[%0d]: got %h exp %h", i, d, exp_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) push(8'h20 + W'(i));
    for (int i = 4; i < 12; i++) begin
      pop(d);
      tests++;
      if (d !== exp_q[i]) begin
        fails++; $display("FAIL wrap_read[%0d]: got %h exp %h", i, d, exp_q[i]);
      end
    end
    tests++;
    if (bus.empty !== 1'b1) begin
      fails++; $display("FAIL wrap_empty: got %b exp 1", bus.empty);
    end
  endtask

  task automatic test_simul_full();
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) push(8'h30 + W'(i));
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 8'h40 + W'(i);
`ifdef FIFO_FWFT_EN
      d = bus.dout;
      cycle();
`else
      cycle();
      d = bus.dout;
`endif
      tests++;
      if (bus.count !== 4'd8 || bus.overflow !== 1'b0 || d !== 8'h30 + W'(i)) begin
        fails++; $display("FAIL simul_full[%0d]: got count=%0d ovf=%b data=%h exp 8/0/%h",
                          i, bus.count, bus.overflow, d, 8'h30 + W'(i));
      end
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop(d);
      tests++;
      if (d !== ((i < 5) ? 8'h33 + W'(i) : 8'h40 + W'(i - 5))) begin
        fails++; $display("FAIL simul_full_order[%0d]: got %h", i, d);
      end
    end
  endtask

  task automatic test_simul_empty();
    logic [W-1:0] d;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.din   = 8'h55;
    cycle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    tests++;
    if (bus.count !== 4'd1 || bus.underflow !== 1'b1 || bus.empty !== 1'b0) begin
      fails++; $display("FAIL simul_empty: got count=%0d unf=%b empty=%b exp 1/1/0",
                        bus.count, bus.underflow, bus.empty);
    end
    pop(d);
    tests++;
    if (d !== 8'h55 || bus.underflow !== 1'b0) begin
      fails++; $display("FAIL simul_empty_data: got %h unf=%b exp 55/0", d, bus.underflow);
    end
  endtask

  task automatic test_gating();
    for (int i = 0; i < 5; i++) push(8'h60 + W'(i));
    bus.fifo_on = 1'b0;
    bus.wr_en   = 1'b1;
    bus.din     = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests++;
      if (bus.count !== 4'd5 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
        fails++; $display("FAIL gating[%0d]: got count=%0d ovf=%b unf=%b exp 5/0/0",
                          i, bus.count, bus.overflow, bus.underflow);
      end
    end
    bus.wr_en   = 1'b0;
    bus.fifo_on = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] d;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      fails++; $display("FAIL async_reset: got count=%0d empty=%b exp 0/1", bus.count, bus.empty);
    end
    #2;
    rst = 1'b0;
    cycle();
    push(8'h77);
    pop(d);
    tests++;
    if (d !== 8'h77 || bus.empty !== 1'b1) begin
      fails++; $display("FAIL post_reset_data: got %h empty=%b exp 77/1", d, bus.empty);
    end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    push(8'hA5);
    tests++;
    if (bus.dout !== 8'hA5 || bus.empty !== 1'b0) begin
      fails++; $display("FAIL fwft_show: got %h empty=%b exp a5/0", bus.dout, bus.empty);
    end
    cycle();
    tests++;
    if (bus.dout !== 8'hA5) begin
      fails++; $display("FAIL fwft_hold: got %h exp a5", bus.dout);
    end
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    tests++;
    if (bus.empty !== 1'b1) begin
      fails++; $display("FAIL fwft_pop: got empty=%b exp 1", bus.empty);
    end
  endtask
`endif

  initial begin
    bus.fifo_on = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.din     = '0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow_wrap();
    test_simul_full();
    test_simul_empty();
    test_gating();
    test_async_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
